// File: rtl/weight_update_unit_pkg.sv
// Shared MLP datapath definitions: sequencer states, saturation bounds, default learning-rate shift.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_SHIFT = 4;

  // Largest positive value of a b-bit signed word, zero-extended to 64 bits.
  function automatic logic [63:0] max_w(input int b);
    return (64'd1 << (b - 1)) - 64'd1;
  endfunction

  // Most negative value of a b-bit signed word, sign-extended to 64 bits.
  function automatic logic [63:0] min_w(input int b);
    return ~((64'd1 << (b - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/weight_update_unit_if.sv
// Streaming bus of the weight update unit: (w, grad) in, (w_new, addr, sat) out.
interface weight_update_unit_if #(
  parameter int bits  = 16,
  parameter int CNT_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [bits-1:0]  w;
  logic [bits-1:0]  grad;
  logic             out_valid;
  logic             out_ready;
  logic [bits-1:0]  w_new;
  logic [CNT_W-1:0] addr;
  logic             sat;

  modport master (
    output in_valid, w, grad, out_ready,
    input  in_ready, out_valid, w_new, addr, sat
  );

  modport slave (
    input  in_valid, w, grad, out_ready,
    output in_ready, out_valid, w_new, addr, sat
  );
endinterface

// File: rtl/weight_update_unit_sat_sub.sv
// Combinational signed a - b with clamping to the bits-wide range.
// Kept standalone so the bias-update path can share it.
module sat_sub
  import mlp_pkg::*;
#(
  parameter int bits = 16
) (
  input  logic signed [bits-1:0] a,
  input  logic signed [bits-1:0] b,
  output logic signed [bits-1:0] y,
  output logic                   sat
);

  localparam logic [63:0]     MAX64 = max_w(bits);
  localparam logic [63:0]     MIN64 = min_w(bits);
  localparam logic [bits-1:0] MAX_V = MAX64[bits-1:0];
  localparam logic [bits-1:0] MIN_V = MIN64[bits-1:0];

  logic signed [bits:0] diff;

  // One extra bit holds the exact difference; its top two bits flag over/underflow.
  always_comb begin
    diff = {a[bits-1], a} - {b[bits-1], b};
    y    = diff[bits-1:0];
    sat  = 1'b0;
    if (diff[bits:bits-1] == 2'b01) begin
      y   = MAX_V;
      sat = 1'b1;
    end else if (diff[bits:bits-1] == 2'b10) begin
      y   = MIN_V;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/weight_update_unit.sv
// Weight update unit: w_new = sat(w - (grad >>> SHIFT)) over a counted sweep,
// two-stage valid/ready pipeline between the gradient buffer and the weight RAM.
//
// state | meaning
// IDLE  | waiting for start; sat_count holds last sweep's value
// RUN   | accepting (w, grad) until in_cnt reaches count
// DRAIN | all inputs taken, waiting for out_cnt to reach count
// DONE  | one-cycle done pulse, then back to IDLE
module weight_update_unit
  import mlp_pkg::*;
#(
  parameter int bits  = 16,
  parameter int SHIFT = DEFAULT_SHIFT,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  weight_update_unit_if.slave bus,
  output logic [CNT_W-1:0] sat_count,
  output logic             busy,
  output logic             done
);

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt_lat, in_cnt, out_cnt;

  logic                   s1_valid;
  logic signed [bits-1:0] s1_w, s1_step;
  logic [CNT_W-1:0]       s1_addr;

  logic                   s2_valid;
  logic signed [bits-1:0] s2_w_new;
  logic                   s2_sat;
  logic [CNT_W-1:0]       s2_addr;

  logic signed [bits-1:0] grad_s, step, res;
  logic                   res_sat;
  logic                   s1_ready, s2_ready, in_ready_int;
  logic                   in_fire, out_fire, start_ok;

  // Handshake qualifiers and the arithmetic shift that turns a gradient into a step.
  always_comb begin
    grad_s       = bus.grad;
    step         = grad_s >>> SHIFT;
    s2_ready     = !s2_valid || bus.out_ready;
    s1_ready     = !s1_valid || s2_ready;
    in_ready_int = (state == RUN) && (in_cnt < cnt_lat) && s1_ready;
    in_fire      = bus.in_valid && in_ready_int;
    out_fire     = s2_valid && bus.out_ready;
    start_ok     = (state == IDLE) && start;
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sequencer next state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? DONE : RUN;
      RUN:     if (in_cnt == cnt_lat) state_nxt = DRAIN;
      DRAIN:   if (out_cnt == cnt_lat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep length latch and transfer counters; in_cnt cannot pass count since in_ready gates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lat   <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      sat_count <= '0;
    end else if (start_ok) begin
      cnt_lat   <= count;
      in_cnt    <= '0;
      out_cnt   <= '0;
      sat_count <= '0;
    end else begin
      if (in_fire) in_cnt <= in_cnt + 1'b1;
      if (out_fire) begin
        out_cnt <= out_cnt + 1'b1;
        if (s2_sat) sat_count <= sat_count + 1'b1;
      end
    end
  end

  // Stage 1: capture weight, step and sweep index; refills whenever stage 2 can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_w     <= '0;
      s1_step  <= '0;
      s1_addr  <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_w    <= bus.w;
        s1_step <= step;
        s1_addr <= in_cnt;
      end
    end
  end

  sat_sub #(.bits(bits)) u_sat_sub (
    .a   (s1_w),
    .b   (s1_step),
    .y   (res),
    .sat (res_sat)
  );

  // Stage 2: saturated result held until the weight RAM accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_w_new <= '0;
      s2_sat   <= 1'b0;
      s2_addr  <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_w_new <= res;
        s2_sat   <= res_sat;
        s2_addr  <= s1_addr;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = s2_valid;
  assign bus.w_new     = s2_w_new;
  assign bus.sat       = s2_sat;
  assign bus.addr      = s2_addr;

endmodule

// File: doc/weight_update_unit.md
Name: weight_update_unit

Overview:
- Backward-pass counterpart to the forward-path adder in the MLP datapath.
- Streams (weight, gradient) pairs and computes w_new = w - (grad >>> SHIFT) in signed fixed point with saturation.
- Runs a counted sweep of `count` weights per start pulse, with valid/ready handshakes on input and output.
- Sits between the gradient buffer and the weight RAM write port.

Parameters:
bits, 16, width of weights, gradients and results (signed two's complement)
SHIFT, 4, learning-rate exponent; step = grad >>> SHIFT (rate = 2^-SHIFT)
CNT_W, 10, width of sweep-length and address counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a sweep; honoured only in IDLE
count  input  CNT_W  number of weights in the sweep; sampled on accepted start
in_valid  input  1  w/grad valid
in_ready  output  1  unit can accept w/grad this cycle
w  input  bits  current weight
grad  input  bits  gradient for this weight
out_valid  output  1  w_new valid
out_ready  input  1  downstream accepts w_new
w_new  output  bits  updated weight
addr  output  CNT_W  index of w_new within the sweep (0..count-1)
sat  output  1  w_new was saturated
sat_count  output  CNT_W  saturated results this sweep
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at sweep completion

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, all counters 0, pipeline valids 0.
- FSM states:
  - IDLE: start=1 -> clear in_cnt, out_cnt and sat_count; latch count; go to RUN, or to DONE if count=0.
  - RUN: accept inputs while in_cnt < count. When in_cnt reaches count, go to DRAIN.
  - DRAIN: wait until out_cnt = count, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- in_ready = (state==RUN) && (in_cnt < count) && stage-1 can advance.
- A transfer occurs when in_valid && in_ready; each transfer increments in_cnt.
- Pipeline:
  - 2 stages, full valid/ready, throughput 1 per cycle.
  - Stage 1 registers w, step, and addr = in_cnt.
  - Stage 2 registers the saturated result, sat, and addr.
  - Latency: 2 cycles from input transfer to out_valid when out_ready is held high.
- Backpressure:
  - out_ready=0 freezes stage 2.
  - Stage 1 may fill its bubble; then in_ready drops.
  - No data loss, no duplication; order preserved.
- Arithmetic:
  - step = arithmetic right shift of grad, truncating toward -inf (e.g. -1 >>> 4 = -1).
  - diff = sign-extended w minus sign-extended step, computed at bits+1.
  - diff > 2^(bits-1)-1 -> w_new = 0x7FFF..., sat=1.
  - diff < -2^(bits-1) -> w_new = 0x8000..., sat=1.
  - Otherwise w_new = diff[bits-1:0], sat=0.
- Each output handshake (out_valid && out_ready) increments out_cnt, and increments sat_count if sat=1.
- sat_count holds its value after DONE until the next accepted start.
- Simultaneous input and output transfers in the same cycle are both honoured.
- A counter at its terminal value never wraps: in_cnt stops at count.
- Reset asserted mid-sweep aborts immediately; in-flight data is discarded and no done pulse is produced.

Decomposition:
- Shared package `mlp_pkg`:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - saturation constants MAX_W / MIN_W as functions of bits
  - default SHIFT
- Sub-module `sat_sub`: combinational bits-wide signed subtract with saturation and sat flag.
  - Reusable by the bias-update path.
  - The forward adder may later gain a saturating sibling built from it.

Test Plan:
1. bits=16, SHIFT=4, count=1, w=0x0100, grad=0x0010 -> step=1; w_new=0x00FF, sat=0, addr=0; out_valid 2 cycles after transfer; done pulse next.
2. w=0x8000, grad=0x7FF0 -> step=0x07FF, underflow; w_new=0x8000, sat=1, sat_count=1.
3. w=0x7FF0, grad=0xFF00 (-256) -> step=-16, overflow; w_new=0x7FFF, sat=1. Also w=0x0000, grad=0xFFFF -> step=-1; w_new=0x0001, sat=0.
4. count=4, four back-to-back inputs, out_ready=0 for 5 cycles then 1:
   - in_ready low once both stages are full.
   - outputs appear in order with addr 0..3, values correct.
   - done exactly once, after the 4th output handshake.
5. count=0 start -> done pulses 2 cycles later, in_ready never 1, out_valid never 1; start pulse during RUN is ignored (count unchanged).
6. rst_n low during RUN after 2 of 4 inputs -> all outputs 0 immediately, busy=0, no done; a new start with count=2 completes normally.
